// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Width constants and the output-word type shared by the pipelined FIR and
// the decimating output buffer that follows it, plus a small width helper.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_SAMPLE_W = 4;
    localparam int FIR_WEIGHT_W = 5;
    // sample width + weight width + 3 accumulation growth bits
    localparam int FIR_OUT_W    = FIR_SAMPLE_W + FIR_WEIGHT_W + 3;

    typedef logic [FIR_OUT_W-1:0] fir_word_t;

    // Width of a counter/pointer covering 0..n-1; never narrower than 1 bit
    // so that n == 1 still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// ---------------------------------------------------------------------------
// fir_sync_fifo
// Single-clock show-ahead FIFO: rdata always presents the oldest entry.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset (pointers and count only)
//   push   in   write wdata this cycle (ignored when full unless popping)
//   wdata  in   WIDTH  data to write
//   pop    in   remove head entry this cycle (ignored when empty)
//   rdata  out  WIDTH  head entry, 0 when empty
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  current occupancy
// ---------------------------------------------------------------------------
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers
    // and count are cleared, and the head is masked while empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_decim_buffer.sv
// ---------------------------------------------------------------------------
// fir_decim_buffer
// Output stage behind the pipelined FIR: keeps one of every DECIM valid
// samples, scales it by >> SHIFT down to WORD_OUT bits, registers it as a
// pending word, pushes it into a small show-ahead FIFO the following cycle
// and presents the FIFO head on a valid/ready handshake.
//
// Build option: define FIR_DECIM_SAT_EN to clamp scaled values above
// 2^WORD_OUT-1 to all ones; otherwise the scaled value is truncated.
//
// Ports:
//   clock       in   rising-edge clock, shared with the FIR
//   reset       in   asynchronous active-low reset
//   fir_in      in   WORD_IN  unsigned FIR output word
//   fir_valid   in   fir_in carries a sample this cycle
//   dout        out  WORD_OUT head-of-FIFO word (0 when empty)
//   dout_valid  out  dout holds data
//   dout_ready  in   consumer accepts dout this cycle
//   overflow    out  sticky: a kept sample was dropped on a full FIFO
//   count       out  FIFO occupancy
// ---------------------------------------------------------------------------
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int WORD_IN  = FIR_OUT_W,
    parameter int WORD_OUT = 8,
    parameter int SHIFT    = 3,
    parameter int DECIM    = 2,
    parameter int DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WORD_IN-1:0]         fir_in,
    input  logic                       fir_valid,
    output logic [WORD_OUT-1:0]        dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              PH_W    = idx_w(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]     phase_q, phase_d;
    logic                pend_q, pend_d;
    logic [WORD_OUT-1:0] pend_word_q, pend_word_d;
    logic                overflow_q, overflow_d;
    logic                keep;
    logic [WORD_OUT-1:0] scaled;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_ok;

    // ---------------- scale / width reduction ----------------
`ifdef FIR_DECIM_SAT_EN
    localparam logic [WORD_IN-1:0] OUT_MAX = WORD_IN'((1 << WORD_OUT) - 1);

    logic [WORD_IN-1:0] shifted;

    assign shifted = fir_in >> SHIFT;
    assign scaled  = (shifted > OUT_MAX) ? '1 : shifted[WORD_OUT-1:0];
`else
    // Plain wrap-around truncation of the shifted word.
    assign scaled = WORD_OUT'(fir_in >> SHIFT);
`endif

    // ---------------- decimation and pending register ----------------
    assign keep   = fir_valid && (phase_q == '0);
    assign pop_ok = dout_valid && dout_ready;

    always_comb begin
        phase_d     = phase_q;
        pend_word_d = pend_word_q;
        if (fir_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
        // The pending word lives for exactly one cycle: it is either pushed
        // or dropped on the next edge, so the flag simply follows keep.
        pend_d = keep;
        if (keep) begin
            pend_word_d = scaled;
        end
        // A full FIFO only loses the word when no pop frees a slot.
        overflow_d = overflow_q | (pend_q & fifo_full & ~pop_ok);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q     <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            overflow_q  <= overflow_d;
        end
    end

    // ---------------- output FIFO ----------------
    fir_sync_fifo #(
        .WIDTH (WORD_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (pend_q),
        .wdata (pend_word_q),
        .pop   (dout_ready),
        .rdata (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign dout_valid = ~fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_buffer
// Directed scenarios followed by randomized traffic. A queue-based model of
// the decimate/scale/buffer behaviour is stepped on every clock edge and
// compared against the DUT on every falling edge; directed scenarios add
// literal expectations at specific cycles.
// ---------------------------------------------------------------------------
module tb_fir_decim_buffer;

    localparam int WI = 12;
    localparam int WO = 8;
    localparam int SH = 3;
    localparam int DC = 2;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

`ifdef FIR_DECIM_SAT_EN
    localparam int SAT_EXP = 255;
`else
    localparam int SAT_EXP = 32;
`endif

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic [WI-1:0] fir_in     = '0;
    logic          fir_valid  = 1'b0;
    logic          dout_ready = 1'b0;
    logic [WO-1:0] dout;
    logic          dout_valid;
    logic          overflow;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    // model state
    int m_q[$];
    int m_phase = 0;
    bit m_pend  = 1'b0;
    int m_word  = 0;
    bit m_ovf   = 1'b0;
    bit m_pop;

    int popped[$];

    always #5 clock = ~clock;

    fir_decim_buffer #(
        .WORD_IN  (WI),
        .WORD_OUT (WO),
        .SHIFT    (SH),
        .DECIM    (DC),
        .DEPTH    (DP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fir_in     (fir_in),
        .fir_valid  (fir_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .count      (count)
    );

    function automatic int scale(input int x);
        int s;
        s = x >> SH;
`ifdef FIR_DECIM_SAT_EN
        return (s > (1 << WO) - 1) ? (1 << WO) - 1 : s;
`else
        return s % (1 << WO);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of at most DP words, a phase modulo DC,
    // a one-slot pending word and a sticky drop flag.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_phase = 0;
                m_pend  = 1'b0;
                m_word  = 0;
                m_ovf   = 1'b0;
            end else begin
                m_pop = (m_q.size() != 0) && dout_ready;
                if (m_pop) begin
                    void'(m_q.pop_front());
                end
                if (m_pend) begin
                    if (m_q.size() < DP) begin
                        m_q.push_back(m_word);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                m_pend = fir_valid && (m_phase == 0);
                if (m_pend) begin
                    m_word = scale(int'(fir_in));
                end
                if (fir_valid) begin
                    m_phase = (m_phase + 1) % DC;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("count", int'(count), m_q.size());
            chk("dout_valid", int'(dout_valid), (m_q.size() != 0) ? 1 : 0);
            chk("overflow", int'(overflow), int'(m_ovf));
            if (m_q.size() != 0) begin
                chk("dout", int'(dout), m_q[0]);
            end else if (!reset) begin
                chk("dout_in_reset", int'(dout), 0);
            end
            if (reset && dout_valid && dout_ready) begin
                popped.push_back(int'(dout));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input int d, input bit r);
        fir_valid  = v;
        fir_in     = WI'(d);
        dout_ready = r;
    endtask

    initial begin
        int vals[4];
        int n31;

        // ---- reset held with live input traffic ----
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
            cyc();
            chk("rst_count", int'(count), 0);
            chk("rst_valid", int'(dout_valid), 0);
            chk("rst_ovf", int'(overflow), 0);
            chk("rst_dout", int'(dout), 0);
        end
        drive(1'b0, 0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_valid", int'(dout_valid), 0);
        end

        // ---- decimation: 8,16,24,32 -> 1,3 ----
        popped.delete();
        vals = '{8, 16, 24, 32};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b1);
            cyc();
        end
        drive(1'b0, 0, 1'b1);
        repeat (4) cyc();
        chk("decim_n", popped.size(), 2);
        if (popped.size() >= 2) begin
            chk("decim_0", popped[0], 1);
            chk("decim_1", popped[1], 3);
        end

        // ---- impulse 0x0F8 on a phase-0 cycle ----
        popped.delete();
        drive(1'b1, 'h0F8, 1'b1);
        cyc();
        chk("imp_lat_n", int'(dout_valid), 0);
        drive(1'b1, 0, 1'b1);
        cyc();
        chk("imp_lat_valid", int'(dout_valid), 1);
        chk("imp_lat_dout", int'(dout), 31);
        repeat (4) begin
            drive(1'b1, 0, 1'b1);
            cyc();
        end
        drive(1'b0, 0, 1'b1);
        repeat (3) cyc();
        n31 = 0;
        foreach (popped[i]) begin
            if (popped[i] == 31) n31++;
        end
        chk("imp_once", n31, 1);
        chk("imp_words", popped.size(), 3);

        // ---- saturation / truncation of 0x900 ----
        drive(1'b1, 'h900, 1'b1);
        cyc();
        drive(1'b1, 0, 1'b1);
        cyc();
        chk("sat_valid", int'(dout_valid), 1);
        chk("sat_dout", int'(dout), SAT_EXP);
        drive(1'b0, 0, 1'b1);
        repeat (3) cyc();

        // ---- full / overflow: 8..40 with consumer stalled ----
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8 * i, 1'b0);
            cyc();
            drive(1'b1, 0, 1'b0);
            cyc();
        end
        drive(1'b0, 0, 1'b0);
        repeat (2) cyc();
        chk("full_count", int'(count), 4);
        chk("full_ovf", int'(overflow), 1);
        popped.delete();
        drive(1'b0, 0, 1'b1);
        repeat (6) cyc();
        chk("drain_n", popped.size(), 4);
        if (popped.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("drain_word", popped[i], i + 1);
            end
        end

        // ---- reset, refill, push and pop on a full FIFO ----
        drive(1'b0, 0, 1'b0);
        reset = 1'b0;
        cyc();
        chk("rst2_ovf", int'(overflow), 0);
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 80 + 8 * i, 1'b0);
            cyc();
            drive(1'b1, 0, 1'b0);
            cyc();
        end
        drive(1'b0, 0, 1'b0);
        repeat (2) cyc();
        chk("pp_pre_count", int'(count), 4);
        drive(1'b1, 112, 1'b0);
        cyc();
        drive(1'b0, 0, 1'b1);
        cyc();
        chk("pp_count", int'(count), 4);
        chk("pp_ovf", int'(overflow), 0);
        chk("pp_head", int'(dout), 11);
        drive(1'b0, 0, 1'b0);
        cyc();
        chk("pp_hold_count", int'(count), 4);
        chk("pp_hold_ovf", int'(overflow), 0);
        drive(1'b0, 0, 1'b1);
        cyc();
        drive(1'b0, 0, 1'b0);
        chk("pre_rst_count", int'(count), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_valid", int'(dout_valid), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // ---- randomized traffic ----
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)));
            if (i == 1000) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
            cyc();
        end
        drive(1'b0, 0, 1'b1);
        repeat (8) cyc();
        chk("final_empty", int'(dout_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Output stage directly downstream of the pipelined FIR filter. It takes the FIR's unsigned output word, decimates it by a fixed factor, and scales it down to a narrower output word. Saturation of that word is optional (see Configuration). Results are buffered in a small FIFO and presented on a valid/ready handshake, so a slow consumer such as a DAC, UART or bus bridge can be attached without stalling the FIR.

## Interface
- WORD_IN, 12: FIR output width (sample 4 + weight 5 + 3 growth bits).
- WORD_OUT, 8: output word width.
- SHIFT, 3: right-shift applied before width reduction.
- DECIM, 2: keep one of every DECIM valid inputs (≥1).
- DEPTH, 4: FIFO entries (power of two, ≥2).

Ports:
- clock  in  1  rising-edge clock, shared with the FIR.
- reset  in  1  asynchronous, active-low reset.
- fir_in  in  WORD_IN  FIR output word, unsigned.
- fir_valid  in  1  fir_in is a valid sample this cycle.
- dout  out  WORD_OUT  head-of-FIFO word.
- dout_valid  out  1  dout holds data.
- dout_ready  in  1  consumer accepts dout this cycle.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Phase counter runs 0..DECIM-1 and advances only on fir_valid. It wraps to 0 after DECIM-1.
- A sample with fir_valid=1 and phase=0 is kept. All other samples are discarded.
- Scale stage: s = fir_in >> SHIFT (unsigned). Width reduction to WORD_OUT follows the Configuration rule.
- The kept, scaled word is registered in the scale register together with a pending flag.
- The next cycle, the pending word is pushed into the FIFO if not full.
  - If full and no pop occurs that cycle, the word is dropped and overflow is set.
  - overflow clears only on reset.
- FIFO is show-ahead: dout is always the oldest entry; dout_valid = (count != 0).
- Pop occurs when dout_valid && dout_ready.
  - dout_ready while empty is ignored.
  - While dout_valid=1 and dout_ready=0, dout and dout_valid are held stable.
- Simultaneous push and pop:
  - Non-empty: both occur and count is unchanged.
  - Full: the pop frees a slot, the push is accepted, and overflow does not set.
  - Empty: the pushed word appears next cycle; no pass-through in the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-release assumed by the system) clears:
  - dout=0, dout_valid=0, overflow=0, count=0.
  - phase=0, pending=0, FIFO pointers=0.
- Reset asserted mid-operation discards the pending word and all FIFO contents immediately.
- Latency: kept sample at edge N → scale register at edge N → FIFO write at edge N+1 → dout/dout_valid visible after edge N+1 (into an empty FIFO).
- Throughput is one kept sample per clock (DECIM=1) with dout_ready held high. No bubbles are allowed.
- count updates on the same edge as the push/pop it reflects.

## Configuration
- FIR_DECIM_SAT_EN defined: if s > 2^WORD_OUT-1, the output is 2^WORD_OUT-1 (all ones). Otherwise the output is s.
- FIR_DECIM_SAT_EN not defined: the output is s[WORD_OUT-1:0] (wrap-around truncation), with no comparator logic.
- overflow is unaffected by saturation in both cases.

## Structure
- Shared package fir_pkg holds:
  - Width constants FIR_SAMPLE_W=4, FIR_WEIGHT_W=5, FIR_OUT_W=12.
  - A typedef for the FIR output word.
  - These are also consumed by the FIR itself.
- Sub-module fir_sync_fifo:
  - Parameterised WIDTH and DEPTH.
  - Push/pop, show-ahead head, count, full/empty.
  - Same clock and reset.
- Top level holds the phase counter, scale/saturation stage, pending register and overflow flag.

## Test plan
- Reset: hold reset=0 for 4 cycles with random fir_in and fir_valid=1 → dout=0, dout_valid=0, overflow=0, count=0 throughout; release and confirm no spurious output.
- Impulse:
  - Stimulus: fir_valid continuous, dout_ready=1; fir_in=0x0F8 on a phase-0 cycle, 0 otherwise.
  - Expected: dout=31 with dout_valid=1 exactly once, after edge N+1.
- Decimation:
  - Stimulus: after reset, fir_in=8,16,24,32 on four consecutive valid cycles.
  - Expected: dout sequence 1,3; the samples 16 and 32 never appear.
- Saturation:
  - Stimulus: fir_in=0x900 (s=288) on a kept cycle.
  - Expected: dout=255 with FIR_DECIM_SAT_EN defined; dout=32 without it.
- Full/overflow:
  - Stimulus: dout_ready=0; 5 kept samples with values 8,16,24,32,40.
  - Expected: count=4, overflow=1, and the fifth sample (40) is dropped. Raising dout_ready drains 1,2,3,4 in order.
- Full with simultaneous push/pop, then reset mid-stream:
  - Stimulus: FIFO full; pulse dout_ready on the cycle a pending word pushes; later assert reset with count=3.
  - Expected: count stays 4 and overflow stays 0 at the push/pop cycle. The reset immediately forces count=0 and dout_valid=0.
